// File: rtl/line_buffer_5row.sv
// rtl/line_buffer_5row.sv - four-row line buffer producing 5-pixel vertical columns
// for a raster grey stream, with frame position tracking and fill-up gating.
module line_buffer_5row #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_sof,
   input  logic        i_valid,
   input  logic [7:0]  i_pixel,
   output logic [39:0] o_col0,
   output logic        o_valid,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_frame_done
);
   localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [11:0] X_LAST      = 12'(WIDTH - 1);
   localparam logic [11:0] Y_LAST      = 12'(HEIGHT - 1);
   localparam logic [11:0] Y_FILL_LAST = 12'd3;

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   state_t      state;
   logic [11:0] x;
   logic [11:0] y;

   logic [7:0]  l0 [0:WIDTH-1];
   logic [7:0]  l1 [0:WIDTH-1];
   logic [7:0]  l2 [0:WIDTH-1];
   logic [7:0]  l3 [0:WIDTH-1];

   logic          accept;
   logic [11:0]   px;
   logic [11:0]   py;
   logic [AW-1:0] addr;
   logic          x_wrap;
   logic          last_pix;
   logic [7:0]    rd0;
   logic [7:0]    rd1;
   logic [7:0]    rd2;
   logic [7:0]    rd3;

   // A start-of-frame pixel always lands at (0,0), whatever the counters say.
   always_comb begin
      accept   = i_valid && (i_sof || (state != IDLE));
      px       = i_sof ? 12'd0 : x;
      py       = i_sof ? 12'd0 : y;
      addr     = px[AW-1:0];
      x_wrap   = (px == X_LAST);
      last_pix = x_wrap && (py == Y_LAST);
   end

   assign rd0 = l0[addr];
   assign rd1 = l1[addr];
   assign rd2 = l2[addr];
   assign rd3 = l3[addr];

   // Line memories shift one row down per accepted pixel; no reset needed.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         l0[addr] <= i_pixel;
         l1[addr] <= rd0;
         l2[addr] <= rd1;
         l3[addr] <= rd2;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         x            <= 12'd0;
         y            <= 12'd0;
         o_col0       <= 40'd0;
         o_valid      <= 1'b0;
         o_x          <= 12'd0;
         o_y          <= 12'd0;
         o_frame_done <= 1'b0;
      end else begin
         o_valid      <= 1'b0;
         o_frame_done <= 1'b0;
         if (accept) begin
            o_col0       <= {rd3, rd2, rd1, rd0, i_pixel};
            o_x          <= px;
            o_y          <= py;
            o_valid      <= (state == STREAM) && !i_sof;
            o_frame_done <= (state == STREAM) && !i_sof && last_pix;
            if (x_wrap) begin
               x <= 12'd0;
               y <= (py == Y_LAST) ? 12'd0 : py + 12'd1;
            end else begin
               x <= px + 12'd1;
               y <= py;
            end
            if (last_pix)
               state <= IDLE;
            else if (i_sof)
               state <= FILL;
            else if ((state == FILL) && x_wrap && (py == Y_FILL_LAST))
               state <= STREAM;
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_5row.sv
// tb/tb_line_buffer_5row.sv - randomized bench for line_buffer_5row against an
// image-array reference model.
module tb_line_buffer_5row;
   localparam int W = 8;
   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sof = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  pixel = 8'd0;
   logic [39:0] col0;
   logic        ov;
   logic [11:0] ox;
   logic [11:0] oy;
   logic        done;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0]  img [0:H-1][0:W-1];
   int          mx, my;
   bit          active;
   logic [39:0] e_col;
   bit          col_known;
   int          e_x, e_y;
   bit          e_valid, e_done;

   line_buffer_5row #(.WIDTH(W), .HEIGHT(H)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof), .i_valid(valid), .i_pixel(pixel),
      .o_col0(col0), .o_valid(ov), .o_x(ox), .o_y(oy), .o_frame_done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      active = 0; mx = 0; my = 0;
      e_col = '0; col_known = 1; e_x = 0; e_y = 0; e_valid = 0; e_done = 0;
   endtask

   task automatic check_outputs();
      check("o_valid", 64'(ov), 64'(e_valid));
      check("o_frame_done", 64'(done), 64'(e_done));
      check("o_x", 64'(ox), 64'(e_x));
      check("o_y", 64'(oy), 64'(e_y));
      if (col_known) check("o_col0", 64'(col0), 64'(e_col));
   endtask

   // One clock of stimulus; the model keeps the frame as a 2-D image.
   task automatic step(input bit s, input bit v, input bit pattern);
      bit         acc;
      int         px, py;
      logic [7:0] p;
      px = s ? 0 : mx;
      py = s ? 0 : my;
      p  = pattern ? 8'((16 * py + px) & 255) : 8'($urandom_range(0, 255));
      @(negedge clk);
      sof = s; valid = v; pixel = p;
      acc = v && (s || active);
      e_valid = 0; e_done = 0;
      if (acc) begin
         active = 1;
         img[py][px] = p;
         e_x = px; e_y = py;
         e_valid = (py >= 4);
         e_done  = e_valid && (px == W - 1) && (py == H - 1);
         col_known = e_valid;
         if (e_valid)
            e_col = {img[py-4][px], img[py-3][px], img[py-2][px], img[py-1][px], p};
         if (px == W - 1) begin
            mx = 0;
            if (py == H - 1) begin my = 0; active = 0; end
            else my = py + 1;
         end else begin
            mx = px + 1; my = py;
         end
      end
      @(posedge clk); #1;
      check_outputs();
      if (pattern && acc && px == 0 && py == 4) check("col_at_0_4", 64'(col0), 64'h0010203040);
      if (pattern && acc && px == W - 1 && py == H - 1) begin
         check("col_at_7_5", 64'(col0), 64'h1727374757);
         check("done_at_7_5", 64'(done), 64'd1);
      end
   endtask

   // bubbles: 0 none, 1 every other cycle once five rows are in, 2 random
   task automatic frame(input bit pattern, input int bubbles);
      step(1, 1, pattern);
      for (int i = 1; i < W * H; i++) begin
         if ((bubbles == 1 && my >= 4) || (bubbles == 2 && $urandom_range(0, 3) == 0))
            step(0, 0, pattern);
         step(0, 1, pattern);
      end
      step(0, 0, pattern);
   endtask

   task automatic async_reset_check();
      #2 rst_n = 1'b0;
      #1;
      check("rst_col0", 64'(col0), 64'd0);
      check("rst_valid", 64'(ov), 64'd0);
      check("rst_x", 64'(ox), 64'd0);
      check("rst_y", 64'(oy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_col0", 64'(col0), 64'd0);
      check("reset_valid", 64'(ov), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      frame(1, 0);
      frame(1, 1);

      for (int i = 0; i < 10; i++) step(0, 1, 1);
      frame(1, 0);

      // Restart mid-frame at (3,4), then let the new frame run to completion.
      step(1, 1, 1);
      while (!(mx == 3 && my == 4)) step(0, 1, 1);
      frame(1, 0);

      // Asynchronous reset while pixel (2,5) is presented.
      step(1, 1, 1);
      while (!(mx == 2 && my == 5)) step(0, 1, 1);
      @(negedge clk);
      sof = 0; valid = 1; pixel = 8'h52;
      async_reset_check();
      frame(1, 0);

      for (int f = 0; f < 3; f++) frame(0, 2);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 60) == 0, $urandom_range(0, 9) < 8, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/line_buffer_5row.md
Name: line_buffer_5row

Overview:
Upstream neighbour of the 5x5 Gaussian smoothing stage. It accepts a raster-order 8-bit grey pixel stream and buffers four full image rows. For every accepted pixel it emits a 40-bit vertical column of 5 pixels (top to bottom), which is exactly the input format the smoothing stage consumes. It also tracks frame position and suppresses output until five rows are available.

Parameters:
WIDTH, 640, pixels per row (column counter wraps at WIDTH-1)
HEIGHT, 480, rows per frame (row counter wraps at HEIGHT-1)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_sof  input  1  start-of-frame; qualifies the first pixel of a frame
i_valid  input  1  i_pixel valid this cycle
i_pixel  input  8  incoming raster pixel
o_col0  output  40  [39:32]=row y-4, [31:24]=y-3, [23:16]=y-2, [15:8]=y-1, [7:0]=row y (current pixel); all at column x
o_valid  output  1  o_col0 valid
o_x  output  12  column of the pixel that produced o_col0
o_y  output  12  row of the pixel that produced o_col0 (bottom row of the column)
o_frame_done  output  1  one-cycle pulse with the last column of a frame

Behaviour:
- Reset (async, i_rst_n=0): o_col0=0, o_valid=0, o_x=0, o_y=0, o_frame_done=0, x=y=0, state=IDLE.
- Line memories (4 x WIDTH x 8) are not reset. Stale contents are never exposed because of o_valid gating.
- Storage: four line memories L0..L3 indexed by x. On an accepted pixel at (x,y):
  - L0[x]<=i_pixel, L1[x]<=L0[x], L2[x]<=L1[x], L3[x]<=L2[x]. All read-before-write, same cycle.
  - The column is {L3[x],L2[x],L1[x],L0[x],i_pixel}.
- Latency: exactly 1 cycle. Outputs are registered on the edge that accepts the pixel.
- When i_valid=0: o_valid=0; o_col0, o_x and o_y hold their last values; no counter or memory change.
- FSM states:
  - IDLE: i_valid without i_sof is ignored. i_valid&i_sof accepts the pixel as (0,0) and goes to FILL.
  - FILL (y<4): pixels are accepted and stored; o_valid=0. When the pixel at (WIDTH-1,3) is accepted, go to STREAM.
  - STREAM (y>=4): o_valid=1 for every accepted pixel.
  - After the pixel at (WIDTH-1,HEIGHT-1) is accepted: o_frame_done=1 alongside that column, go to IDLE, x=y=0.
- Counters:
  - x increments per accepted pixel and wraps WIDTH-1 -> 0.
  - y increments on the x wrap.
- i_sof with i_valid in FILL/STREAM (restart mid-frame):
  - The pixel is taken as (0,0) and the state goes to FILL.
  - No o_valid until 4 new rows are complete; no o_frame_done for the aborted frame.
- i_sof without i_valid: ignored.
- Reset asserted mid-frame: immediate return to reset values. The next frame requires i_sof.
- HEIGHT<5 is unsupported (the block never enters STREAM).
- No backpressure: the downstream stage must accept one column per valid cycle.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=6, pixel=(16*y+x)&0xFF, continuous i_valid.
1. Reset then one full frame: o_valid stays 0 for the first 32 pixels. The pixel at (0,4) yields, one cycle later, o_col0=0x0010203040, o_x=0, o_y=4, o_valid=1.
2. Same frame, pixel (7,5): o_col0=0x1727374757, o_valid=1, o_frame_done=1 on that cycle only. The next cycle shows state IDLE, o_valid=0.
3. Insert i_valid=0 bubbles every other cycle during STREAM: columns are identical to scenario 1, and o_col0/o_x/o_y hold during bubbles with o_valid=0.
4. i_valid without i_sof after reset (10 pixels), then a proper frame: the first 10 pixels are ignored and the frame matches scenario 1 exactly.
5. i_sof at pixel (3,4) of frame 1: no o_frame_done; o_valid=0 for the next 32 pixels; the first new valid column is at new (0,4).
6. Assert i_rst_n=0 at pixel (2,5): all outputs are 0 within the same cycle (async). After release, a new frame (i_sof) behaves as scenario 1.
